// File: rtl/neuron_out_backprop.sv
// neuron_out_backprop
// Backward pass of the output neuron. One start request runs a fixed
// eight-state sequence: output error, hidden-neuron errors, scaled delta,
// then updates of both weights and the bias. A single shared multiplier
// serves every product; an FSM selects its operands each cycle.
// All values are Q5.15, 20-bit signed. Products are floored (>>> 15) and
// truncated to 20 bits; add/subtract wrap.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   start             request one training step (sampled only in IDLE)
//   N1_1, N1_2        hidden neuron outputs from the forward pass
//   N2_out, target    forward output and desired output
//   lr                learning rate
//   busy              high whenever the FSM is not idle
//   done              one-cycle pulse when the step has completed
//   err_out           N2_out - target
//   dH1, dH2          errors propagated to the hidden neurons
//   Wn_1, Wn_2        current output-neuron weights
//   B_neuron          current output-neuron bias
module neuron_out_backprop #(
  parameter logic signed [19:0] W1_INIT = 20'sd32768,
  parameter logic signed [19:0] W2_INIT = 20'sd32768,
  parameter logic signed [19:0] B_INIT  = 20'sd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic signed [19:0] N1_1,
  input  logic signed [19:0] N1_2,
  input  logic signed [19:0] N2_out,
  input  logic signed [19:0] target,
  input  logic signed [19:0] lr,
  output logic               busy,
  output logic               done,
  output logic signed [19:0] err_out,
  output logic signed [19:0] dH1,
  output logic signed [19:0] dH2,
  output logic signed [19:0] Wn_1,
  output logic signed [19:0] Wn_2,
  output logic signed [19:0] B_neuron
);

  typedef enum logic [3:0] {
    S_IDLE, S_ERR, S_HD1, S_HD2, S_DLT, S_UW1, S_UW2, S_UB, S_DONE
  } state_t;

  state_t state;

  logic signed [19:0] n1_1_l, n1_2_l, n2_out_l, target_l, lr_l;
  logic signed [19:0] d;

  logic signed [19:0] mul_a, mul_b;
  logic signed [39:0] prod;
  logic signed [19:0] prod_q;

  // Operand select for the shared multiplier; idle states feed zeros.
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state)
      S_HD1: begin mul_a = err_out; mul_b = Wn_1;   end
      S_HD2: begin mul_a = err_out; mul_b = Wn_2;   end
      S_DLT: begin mul_a = err_out; mul_b = lr_l;   end
      S_UW1: begin mul_a = d;       mul_b = n1_1_l; end
      S_UW2: begin mul_a = d;       mul_b = n1_2_l; end
      default: ;
    endcase
  end

  // Full 40-bit signed product, floor shift, keep the low 20 bits.
  assign prod   = 40'(mul_a) * 40'(mul_b);
  assign prod_q = 20'(prod >>> 15);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      err_out  <= '0;
      dH1      <= '0;
      dH2      <= '0;
      Wn_1     <= W1_INIT;
      Wn_2     <= W2_INIT;
      B_neuron <= B_INIT;
      n1_1_l   <= '0;
      n1_2_l   <= '0;
      n2_out_l <= '0;
      target_l <= '0;
      lr_l     <= '0;
      d        <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            n1_1_l   <= N1_1;
            n1_2_l   <= N1_2;
            n2_out_l <= N2_out;
            target_l <= target;
            lr_l     <= lr;
            busy     <= 1'b1;
            state    <= S_ERR;
          end
        end
        S_ERR: begin
          err_out <= n2_out_l - target_l;
          state   <= S_HD1;
        end
        S_HD1: begin
          dH1   <= prod_q;
          state <= S_HD2;
        end
        S_HD2: begin
          dH2   <= prod_q;
          state <= S_DLT;
        end
        S_DLT: begin
          d     <= prod_q;
          state <= S_UW1;
        end
        S_UW1: begin
          Wn_1  <= Wn_1 - prod_q;
          state <= S_UW2;
        end
        S_UW2: begin
          Wn_2  <= Wn_2 - prod_q;
          state <= S_UB;
        end
        S_UB: begin
          B_neuron <= B_neuron - d;
          done     <= 1'b1;
          state    <= S_DONE;
        end
        S_DONE: begin
          // Returning to IDLE takes this edge; start is not sampled here.
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_out_backprop.sv
module tb_neuron_out_backprop;

  logic               clk;
  logic               rst_n;
  logic               start;
  logic signed [19:0] N1_1, N1_2, N2_out, target, lr;
  logic               busy, done;
  logic signed [19:0] err_out, dH1, dH2, Wn_1, Wn_2, B_neuron;

  int checks;
  int errors;

  localparam logic signed [19:0] W1I = 20'sd32768;
  localparam logic signed [19:0] W2I = -20'sd16384;
  localparam logic signed [19:0] BI  = 20'sd0;

  neuron_out_backprop #(
    .W1_INIT(W1I),
    .W2_INIT(W2I),
    .B_INIT (BI)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .N1_1    (N1_1),
    .N1_2    (N1_2),
    .N2_out  (N2_out),
    .target  (target),
    .lr      (lr),
    .busy    (busy),
    .done    (done),
    .err_out (err_out),
    .dH1     (dH1),
    .dH2     (dH2),
    .Wn_1    (Wn_1),
    .Wn_2    (Wn_2),
    .B_neuron(B_neuron)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [19:0] n1_1, n1_2, n2, tgt, lr;
    logic signed [19:0] e_err, e_dh1, e_dh2, e_w1, e_w2, e_b;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic signed [19:0] act,
                     input logic signed [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_bits(input string name, input logic [31:0] act,
                          input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_in(input logic signed [19:0] a, b, c, t, l);
    N1_1 = a; N1_2 = b; N2_out = c; target = t; lr = l;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic chk_outputs(input string tag, input vec_t v);
    chk({tag, " err_out"},  err_out,  v.e_err);
    chk({tag, " dH1"},      dH1,      v.e_dh1);
    chk({tag, " dH2"},      dH2,      v.e_dh2);
    chk({tag, " Wn_1"},     Wn_1,     v.e_w1);
    chk({tag, " Wn_2"},     Wn_2,     v.e_w2);
    chk({tag, " B_neuron"}, B_neuron, v.e_b);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " busy"},     {19'd0, busy}, 20'sd0);
    chk({tag, " done"},     {19'd0, done}, 20'sd0);
    chk({tag, " err_out"},  err_out,  20'sd0);
    chk({tag, " dH1"},      dH1,      20'sd0);
    chk({tag, " dH2"},      dH2,      20'sd0);
    chk({tag, " Wn_1"},     Wn_1,     W1I);
    chk({tag, " Wn_2"},     Wn_2,     W2I);
    chk({tag, " B_neuron"}, B_neuron, BI);
  endtask

  // One step: start for one cycle, scramble inputs in cycle 2 to prove
  // they were latched, record busy/done in cycles 1..9, then check results.
  task automatic run_step(input string tag, input vec_t v);
    logic [8:0] busy_seen, done_seen;
    busy_seen = '0;
    done_seen = '0;
    @(negedge clk);
    set_in(v.n1_1, v.n1_2, v.n2, v.tgt, v.lr);
    start = 1'b1;
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (c == 2) set_in(20'sd77, -20'sd5000, 20'sd123456, -20'sd999, 20'sd30000);
      busy_seen[c-1] = busy;
      done_seen[c-1] = done;
    end
    chk_bits({tag, " busy_timing"}, {23'd0, busy_seen}, {23'd0, 9'b0_1111_1111});
    chk_bits({tag, " done_timing"}, {23'd0, done_seen}, {23'd0, 9'b0_1000_0000});
    chk_outputs(tag, v);
  endtask

  vec_t nom;
  vec_t nom2;

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    set_in('0, '0, '0, '0, '0);

    // n1_1, n1_2, n2, tgt, lr, err, dh1, dh2, w1, w2, b
    vecs[0] = '{20'sd16384, 20'sd32768, 20'sd49152, 20'sd32768, 20'sd3277,
                20'sd16384, 20'sd16384, -20'sd8192, 20'sd31949, -20'sd18022, -20'sd1638};
    vecs[1] = '{20'sd32768, 20'sd32768, 20'sd0, 20'sd1, 20'sd3277,
                -20'sd1, -20'sd1, 20'sd0, 20'sd32769, -20'sd16383, 20'sd1};
    vecs[2] = '{20'sd16384, 20'sd32768, 20'sd524287, -20'sd524288, 20'sd3277,
                -20'sd1, -20'sd1, 20'sd0, 20'sd32769, -20'sd16383, 20'sd1};
    vecs[3] = '{-20'sd32768, 20'sd8192, 20'sd0, 20'sd65536, 20'sd16384,
                -20'sd65536, -20'sd65536, 20'sd32768, 20'sd0, -20'sd8192, 20'sd32768};
    vecs[4] = '{20'sd1000, 20'sd1000, 20'sd100, 20'sd0, 20'sd0,
                20'sd100, 20'sd100, -20'sd50, 20'sd32768, -20'sd16384, 20'sd0};
    vecs[5] = '{-20'sd3, 20'sd1, 20'sd3, 20'sd0, 20'sd32768,
                20'sd3, 20'sd3, -20'sd2, 20'sd32769, -20'sd16384, -20'sd3};

    nom = vecs[0];
    // Second back-to-back step starts from the weights left by the first.
    nom2 = '{20'sd16384, 20'sd32768, 20'sd49152, 20'sd32768, 20'sd3277,
             20'sd16384, 20'sd15974, -20'sd9011, 20'sd31130, -20'sd19660, -20'sd3276};

    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Idle with no start: reset values hold.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk_reset_vals($sformatf("idle%0d", i));
    end

    // Table-driven steps, each from freshly reset weights.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      run_step($sformatf("vec%0d", i), vecs[i]);
    end

    // start held high throughout: one step per 9 edges, inputs disturbed
    // in cycles 2..4 must not matter.
    begin
      logic [16:0] busy_seen, done_seen;
      busy_seen = '0;
      done_seen = '0;
      do_reset();
      @(negedge clk);
      set_in(nom.n1_1, nom.n1_2, nom.n2, nom.tgt, nom.lr);
      start = 1'b1;
      for (int c = 1; c <= 17; c++) begin
        @(negedge clk);
        if (c == 2) set_in(-20'sd1, 20'sd5, 20'sd400000, 20'sd7, 20'sd20000);
        if (c == 5) set_in(nom.n1_1, nom.n1_2, nom.n2, nom.tgt, nom.lr);
        busy_seen[c-1] = busy;
        done_seen[c-1] = done;
        if (c == 8) chk_outputs("b2b_first", nom);
      end
      start = 1'b0;
      chk_bits("b2b busy_timing", {15'd0, busy_seen}, {15'd0, 17'b1_1111_1110_1111_1111});
      chk_bits("b2b done_timing", {15'd0, done_seen}, {15'd0, 17'b1_0000_0000_1000_0000});
      chk_outputs("b2b_second", nom2);
    end

    // Reset asserted while the FSM sits in UW1.
    begin
      logic done_any;
      done_any = 1'b0;
      @(negedge clk);
      set_in(nom.n1_1, nom.n1_2, nom.n2, nom.tgt, nom.lr);
      start = 1'b1;
      for (int c = 1; c <= 5; c++) begin
        @(negedge clk);
        if (c == 1) start = 1'b0;
      end
      chk_bits("pre_reset busy", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset_vals("midrst");
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        done_any = done_any | done;
      end
      chk_bits("midrst no_done", {31'd0, done_any}, 32'd0);
      chk_reset_vals("midrst_hold");
      run_step("after_rst", nom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
